collision_scheduler: RTL
========================

COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, sets the number of collision requesters (players/projectiles).
REQ-002 Parameter X_MAX, default 10'd639, sets the last valid terrain column.
REQ-003 Port clk  in  1  system clock; all logic is on the rising edge; one clock domain.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port req  in  N_REQ  per-requester collision request level, held high until that requester's done pulse.
REQ-006 Port req_x, req_y, req_radius  in  10*N_REQ each  packed per requester; slice i is bits [10i+9:10i].
REQ-007 Port col_rd  out  1  one-cycle terrain column read strobe.
REQ-008 Port col_addr  out  10  column index for col_rd; held stable until col_valid.
REQ-009 Port col_valid  in  1  one-cycle strobe: col_data is valid this cycle.
REQ-010 Port col_data  in  512  terrain column; bit k=1 means solid at row k.
REQ-011 Port busy  out  1  high whenever the state is not IDLE.
REQ-012 Port grant_id  out  $clog2(N_REQ)  index of the requester being serviced; valid while busy.
REQ-013 Port done  out  N_REQ  one-cycle pulse on bit i when requester i's result is updated.
REQ-014 Port res_dd, res_uu, res_impact  out  N_REQ each  registered per-requester results; held until that requester's next done.

Function
REQ-015 The FSM SHALL have states IDLE, RD_C, WT_C, RD_L, WT_L, RD_R, WT_R, FIN.
REQ-016 In IDLE with any req bit set, arbitration SHALL be round-robin: search starts at (last_grant+1) mod N_REQ; first set bit wins; after reset last_grant=N_REQ-1, so requester 0 has first priority.
REQ-017 On grant, X, Y and radius of the winner SHALL be latched; later changes to req_* SHALL NOT affect the transaction.
REQ-018 RD_C SHALL assert col_rd for one cycle with col_addr=X, then go to WT_C.
REQ-019 In WT_C on col_valid: dd = (Y+radius > 511) ? 1 : col_data[Y+radius]; uu = (radius > Y) ? 0 : col_data[Y-radius]; if dd=1 then uu is forced to 0 (down has priority); next state RD_L.
REQ-020 Sums SHALL be computed 11 bits wide; no index SHALL wrap modulo 1024.
REQ-021 RD_L: if X < 4, the left sample SHALL be 0 and the state SHALL go straight to RD_R with no col_rd; otherwise col_rd pulses with col_addr=X-4, and on col_valid in WT_L the left sample = (Y>511) ? 0 : col_data[Y].
REQ-022 RD_R: if X+4 > X_MAX, the right sample SHALL be 0 and the state SHALL go to FIN with no col_rd; otherwise col_rd pulses with col_addr=X+4, and WT_R samples as in REQ-021.
REQ-023 impact SHALL equal the left sample OR the right sample.
REQ-024 In FIN, res_dd[g], res_uu[g] and res_impact[g] SHALL update, done[g] SHALL pulse for one cycle, last_grant SHALL be set to g, and the state SHALL return to IDLE; results for other requesters SHALL remain unchanged.
REQ-025 col_valid outside WT_C/WT_L/WT_R SHALL be ignored.
REQ-026 The WT states SHALL wait indefinitely for col_valid; there is no timeout.
REQ-027 A requester dropping req mid-transaction SHALL NOT abort it; done still pulses.
REQ-028 Minimum latency with a 1-cycle col_valid response SHALL be 8 cycles from grant to done (1 cycle in IDLE, plus each RD and WT state, plus FIN).
REQ-029 A new grant SHALL NOT occur in the same cycle as FIN; the earliest next grant is the IDLE cycle after it.

Reset
REQ-030 While reset is high, the state SHALL be IDLE; busy, col_rd, done, res_dd, res_uu and res_impact SHALL be 0; col_addr=0; grant_id=0; last_grant=N_REQ-1.
REQ-031 Reset asserted mid-transaction SHALL abandon it with no done pulse; a col_valid arriving after reset SHALL be ignored.

Verification
REQ-032 Flat ground: req[0]=1, X=100, Y=200, r=8, column 100 solid at rows >=208, columns 96/104 clear -> col_addr sequence 100, 96, 104; res_dd[0]=1, res_uu[0]=0, res_impact[0]=0; done[0] pulses once.
REQ-033 Ceiling and side hit: X=50, Y=300, r=5, col 50 bit 295=1 and bit 305=0, col 54 bit 300=1 -> res_dd=0, res_uu=1, res_impact=1.
REQ-034 Edges: X=2, Y=3, r=10 -> no left read (only col_addr 2 and 6 issued), uu=0 by underflow; X=637, Y=505, r=10 -> no right read, dd=1 by overflow.
REQ-035 Round-robin: req=4'b1011 held continuously -> done order 0, 1, 3, 0, 1, 3; no requester is starved.
REQ-036 Reset in WT_L with col_valid arriving 2 cycles later -> no done pulse, all outputs 0, next req[2] is served normally.
REQ-037 Back-pressure: col_valid delayed 20 cycles per read -> col_addr stays stable, col_rd pulses exactly 3 times, and results match the 1-cycle-response case.

Source files
------------

// File: rtl/collision_scheduler.sv
// collision_scheduler: round-robin arbiter plus sequencer that samples the
// terrain around one requester's sprite (centre column above/below, and the
// columns four pixels left/right at the sprite's own row) and posts
// per-requester down/up/side-impact results.
module collision_scheduler #(
  parameter int         N_REQ = 4,
  parameter logic [9:0] X_MAX = 10'd639,
  localparam int        GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [10*N_REQ-1:0]  req_x,
  input  logic [10*N_REQ-1:0]  req_y,
  input  logic [10*N_REQ-1:0]  req_radius,
  output logic                 col_rd,
  output logic [9:0]           col_addr,
  input  logic                 col_valid,
  input  logic [511:0]         col_data,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic [N_REQ-1:0]     done,
  output logic [N_REQ-1:0]     res_dd,
  output logic [N_REQ-1:0]     res_uu,
  output logic [N_REQ-1:0]     res_impact
);

  typedef enum logic [2:0] {IDLE, RD_C, WT_C, RD_L, WT_L, RD_R, WT_R, FIN} state_t;

  state_t        state, state_nx;
  logic [9:0]    x_q, y_q, r_q;
  logic          dd_q, uu_q, left_q, right_q;
  logic [GW-1:0] last_grant;
  logic          pick_valid;
  logic [GW-1:0] pick_id;

  // Row arithmetic is done one bit wider so no index can wrap.
  logic [10:0] dn_row;
  logic [9:0]  up_row;
  logic        dn_bit, up_bit, side_bit, left_skip, right_skip;

  assign dn_row     = {1'b0, y_q} + {1'b0, r_q};
  assign up_row     = y_q - r_q;
  assign dn_bit     = (dn_row > 11'd511) ? 1'b1 : col_data[dn_row[8:0]];
  assign up_bit     = ((r_q > y_q) || (up_row > 10'd511)) ? 1'b0 : col_data[up_row[8:0]];
  assign side_bit   = (y_q > 10'd511) ? 1'b0 : col_data[y_q[8:0]];
  assign left_skip  = (x_q < 10'd4);
  assign right_skip = (({1'b0, x_q} + 11'd4) > {1'b0, X_MAX});
  assign busy       = (state != IDLE);

  // Round-robin pick: scan from last_grant+1; the nearest set bit wins.
  always_comb begin
    logic [GW-1:0] idx_w;
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx_w = GW'((int'(last_grant) + k) % N_REQ);
      if (req[idx_w]) begin
        pick_valid = 1'b1;
        pick_id    = idx_w;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and column-read outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nx = state;
    col_rd   = 1'b0;
    col_addr = 10'd0;
    unique case (state)
      IDLE: if (pick_valid) state_nx = RD_C;
      RD_C: begin
        col_rd   = 1'b1;
        col_addr = x_q;
        state_nx = WT_C;
      end
      WT_C: begin
        col_addr = x_q;
        if (col_valid) state_nx = RD_L;
      end
      RD_L: begin
        if (left_skip) begin
          state_nx = RD_R;
        end else begin
          col_rd   = 1'b1;
          col_addr = x_q - 10'd4;
          state_nx = WT_L;
        end
      end
      WT_L: begin
        col_addr = x_q - 10'd4;
        if (col_valid) state_nx = RD_R;
      end
      RD_R: begin
        if (right_skip) begin
          state_nx = FIN;
        end else begin
          col_rd   = 1'b1;
          col_addr = x_q + 10'd4;
          state_nx = WT_R;
        end
      end
      WT_R: begin
        col_addr = x_q + 10'd4;
        if (col_valid) state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Transaction capture, terrain sampling and result posting.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= GW'(N_REQ - 1);
      grant_id   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      r_q        <= '0;
      dd_q       <= 1'b0;
      uu_q       <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      done       <= '0;
      res_dd     <= '0;
      res_uu     <= '0;
      res_impact <= '0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: if (pick_valid) begin
          grant_id <= pick_id;
          x_q      <= req_x[int'(pick_id)*10 +: 10];
          y_q      <= req_y[int'(pick_id)*10 +: 10];
          r_q      <= req_radius[int'(pick_id)*10 +: 10];
        end
        WT_C: if (col_valid) begin
          dd_q <= dn_bit;
          uu_q <= dn_bit ? 1'b0 : up_bit;
        end
        RD_L: if (left_skip) left_q <= 1'b0;
        WT_L: if (col_valid) left_q <= side_bit;
        RD_R: if (right_skip) right_q <= 1'b0;
        WT_R: if (col_valid) right_q <= side_bit;
        FIN: begin
          res_dd[grant_id]     <= dd_q;
          res_uu[grant_id]     <= uu_q;
          res_impact[grant_id] <= left_q | right_q;
          done[grant_id]       <= 1'b1;
          last_grant           <= grant_id;
        end
        default: ;
      endcase
    end
  end

endmodule
